sop_controller: RTL
===================

SOP_CONTROLLER -- requirements
Module: sop_controller

Interface
REQ-001 The module SHALL declare parameter WIDTH, default 4: operand width in bits.
REQ-002 The module SHALL declare parameter DEPTH, default 4: number of product terms per sum, minimum 2.
REQ-003 The module SHALL declare parameter ACC_W, default 2*WIDTH+$clog2(DEPTH): accumulator and sum width.
REQ-004 The module SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port `start`, input, 1 bit: begin a new sum-of-products job.
REQ-007 The module SHALL have ports `a_in` and `b_in`, inputs, WIDTH bits each: operand pair being loaded.
REQ-008 The module SHALL have ports `in_valid` (input, 1 bit) and `in_ready` (output, 1 bit): operand-load handshake.
REQ-009 The module SHALL have ports `mult_a` and `mult_b`, outputs, WIDTH bits each: operands driven to the external shared combinational multiplier.
REQ-010 The module SHALL have port `mult_p`, input, 2*WIDTH bits: product returned by that multiplier in the same cycle.
REQ-011 The module SHALL have port `sum`, output, ACC_W bits: sum-of-products result.
REQ-012 The module SHALL have ports `sum_valid` (output, 1 bit) and `sum_ready` (input, 1 bit): result handshake.
REQ-013 The module SHALL have port `busy`, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, MAC and DONE.
REQ-015 IDLE: `start`=1 SHALL transition to LOAD next cycle and clear index counter `cnt`; `start` SHALL be ignored in all other states.
REQ-016 LOAD: `in_ready` SHALL be 1; each cycle with `in_valid`=1 SHALL store (`a_in`,`b_in`) at entry `cnt` of internal operand registers and increment `cnt`; `in_valid`=0 cycles SHALL stall without change.
REQ-017 LOAD: the transfer with `cnt`=DEPTH-1 SHALL transition to MAC, clear `cnt` and clear the accumulator.
REQ-018 MAC: `mult_a`/`mult_b` SHALL equal stored pair `cnt`; each cycle the accumulator SHALL take accumulator + zero-extended `mult_p`, and `cnt` SHALL increment.
REQ-019 MAC: the cycle with `cnt`=DEPTH-1 SHALL transition to DONE; MAC SHALL last exactly DEPTH cycles with no stalls.
REQ-020 `mult_a` and `mult_b` SHALL be 0 outside MAC.
REQ-021 DONE: `sum_valid` SHALL be 1 and `sum` SHALL equal the final accumulator, held stable until `sum_ready`=1.
REQ-022 DONE with `sum_ready`=1 SHALL return to IDLE next cycle; `sum` SHALL retain its value in IDLE until the next MAC entry.
REQ-023 Latency: `sum_valid` SHALL rise exactly DEPTH+1 cycles after the edge accepting the last operand pair.
REQ-024 Accumulation SHALL be unsigned and, with default ACC_W, SHALL NOT overflow for any operands; no saturation logic is required.
REQ-025 `in_ready` SHALL be 0 in IDLE, MAC and DONE; `in_valid` in those states SHALL be ignored.

Reset
REQ-026 `rst`=1 at a rising edge SHALL force IDLE, `cnt`=0, accumulator=0, `sum`=0, `sum_valid`=0, `in_ready`=0, `busy`=0, `mult_a`=`mult_b`=0; operand registers need not be cleared.
REQ-027 `rst` SHALL take priority over `start`, `in_valid` and `sum_ready` in the same cycle.
REQ-028 Reset in LOAD, MAC or DONE SHALL abort the job with no `sum_valid` pulse; a fresh `start` after reset SHALL run a complete new job.

Verification
REQ-029 Defaults, pairs (1,2),(3,4),(5,6),(7,8) loaded back-to-back -> `sum`=100, `sum_valid` 5 cycles after 4th transfer, `busy` high from the cycle after `start`.
REQ-030 All pairs (15,15) -> `sum`=900, no overflow; `mult_a`/`mult_b` show 15 for exactly 4 cycles.
REQ-031 Same job as REQ-029 with `in_valid` low 3 cycles between pairs 2 and 3 -> `sum`=100, `cnt` frozen during gaps.
REQ-032 `sum_ready` held low 5 cycles in DONE -> `sum`=100 and `sum_valid`=1 stable; `start` pulses there are ignored; release -> IDLE.
REQ-033 `rst` during MAC cycle 2 -> next cycle IDLE, `sum`=0, no `sum_valid`; new job (2,2)x4 -> `sum`=16.
REQ-034 `start` and `rst` both high in IDLE -> remains IDLE, `busy`=0.

Source files
------------

// File: rtl/sop_controller.sv
// Sum-of-products controller: loads DEPTH operand pairs, then accumulates their
// products through an external shared combinational multiplier, one per cycle.
module sop_controller #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int ACC_W = 2*WIDTH + $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_p,
  output logic [ACC_W-1:0]   sum,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic               busy
);

  localparam int CNT_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t                      r_state, w_next;
  logic [CNT_W-1:0]            r_cnt;
  logic [DEPTH-1:0][WIDTH-1:0] r_a, r_b;
  logic [ACC_W-1:0]            r_acc;
  logic                        w_last;
  logic                        w_xfer;

  assign w_last = (r_cnt == CNT_W'(DEPTH-1));
  assign w_xfer = (r_state == LOAD) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start)           w_next = LOAD;
      LOAD: if (w_xfer && w_last) w_next = MAC;
      MAC:  if (w_last)          w_next = DONE;
      DONE: if (sum_ready)       w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
  end

  // The accumulator doubles as the result register, so sum stays put through
  // DONE and IDLE and only clears when the next job enters MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) r_cnt <= '0;
        LOAD: if (in_valid) begin
          r_a[r_cnt] <= a_in;
          r_b[r_cnt] <= b_in;
          if (w_last) begin
            r_cnt <= '0;
            r_acc <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        MAC: begin
          r_acc <= r_acc + ACC_W'(mult_p);
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mult_a    = (r_state == MAC) ? r_a[r_cnt] : '0;
  assign mult_b    = (r_state == MAC) ? r_b[r_cnt] : '0;
  assign sum       = r_acc;
  assign sum_valid = (r_state == DONE);
  assign in_ready  = (r_state == LOAD);
  assign busy      = (r_state != IDLE);

endmodule
